fifo_wr_arbiter: RTL and testbench

- Shares the single FIFO write port (write_en/wdata) between NUM_REQ producers using valid/ready handshakes.
- Round-robin grant with bounded bursts; throttles on full/amst_full so the FIFO never overflows.
- Sits between producer agents/blocks and the FIFO write side, on the same clk as the FIFO.
- Latches the FIFO error flag into a sticky status.

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/fifo_rr_picker.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 131 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-side arbiter and its
// round-robin picker.
package fifo_arb_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_picker.sv
// Combinational round-robin search: first asserted request strictly after ptr,
// wrapping from N-1 back to 0 (N need not be a power of two).
module fifo_rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              req,
  input  logic [idx_width(N)-1:0]   ptr,
  output logic                      found,
  output logic [idx_width(N)-1:0]   idx
);

  localparam int W = idx_width(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = ptr;
    for (int k = 0; k < N; k++) begin
      cand = (cand == LAST) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port between NUM_REQ valid/ready producers with
// round-robin bursts, space-aware throttling and a sticky FIFO error flag.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            write_en,
  output logic [DATA_WIDTH-1:0]           wdata,
  input  logic                            full,
  input  logic                            amst_full,
  input  logic                            error,
  output logic                            grant_valid,
  output logic [idx_width(NUM_REQ)-1:0]   grant_id,
  output logic                            err_sticky
);

  localparam int GW = idx_width(NUM_REQ);
  localparam int CW = idx_width(BURST_LEN + 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_LEN);
  localparam logic [GW-1:0] PTR_RST    = GW'(NUM_REQ - 1);

  arb_state_e              state_q, state_d;
  logic [GW-1:0]           grant_id_q, grant_id_d;
  logic [GW-1:0]           ptr_q, ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    write_en_q, write_en_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    err_sticky_q, err_sticky_d;

  logic [DATA_WIDTH-1:0]   req_word [NUM_REQ];
  logic                    pick_found;
  logic [GW-1:0]           pick_idx;
  logic                    space_ok;
  logic                    cur_valid;
  logic                    accept;
  logic [CW-1:0]           cnt_inc;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_word[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  fifo_rr_picker #(
    .N (NUM_REQ)
  ) u_picker (
    .req   (req_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // A write already in flight consumes the last free slot when almost full.
  assign space_ok  = !full && !(amst_full && write_en_q);
  assign cur_valid = req_valid[grant_id_q];
  assign accept    = (state_q == ARB_BURST) && space_ok && cur_valid && !rst;
  assign cnt_inc   = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      grant_id_q   <= '0;
      ptr_q        <= PTR_RST;
      cnt_q        <= '0;
      write_en_q   <= 1'b0;
      wdata_q      <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      write_en_q   <= write_en_d;
      wdata_q      <= wdata_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    write_en_d   = accept;
    wdata_d      = accept ? req_word[grant_id_q] : wdata_q;
    err_sticky_d = err_sticky_q | error;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d    = ARB_BURST;
          grant_id_d = pick_idx;
          cnt_d      = '0;
        end
      end
      ARB_BURST: begin
        if (accept) begin
          cnt_d = cnt_inc;
        end
        // Throttling never ends a burst; only a full burst or a dropped valid does.
        if ((accept && cnt_inc == BURST_LAST) || !cur_valid) begin
          state_d = ARB_IDLE;
          ptr_d   = grant_id_q;
          cnt_d   = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = '0;
    grant_valid = (state_q == ARB_BURST);
    if (state_q == ARB_BURST && !rst) begin
      req_ready[grant_id_q] = space_ok && cur_valid;
    end
  end

  assign write_en   = write_en_q;
  assign wdata      = wdata_q;
  assign grant_id   = grant_id_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboarded bench: producer queues and a FIFO occupancy model drive the
// arbiter; expected writes come from a burst-level round-robin model.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              write_en;
  logic [DW-1:0]     wdata;
  logic              full;
  logic              amst_full;
  logic              error;
  logic              grant_valid;
  logic [1:0]        grant_id;
  logic              err_sticky;

  logic              b_rst;
  logic [2:0]        b_req_valid;
  logic [3*DW-1:0]   b_req_data;
  logic [2:0]        b_req_ready;
  logic              b_write_en;
  logic [DW-1:0]     b_wdata;
  logic              b_full;
  logic              b_amst_full;
  logic              b_error;
  logic              b_grant_valid;
  logic [1:0]        b_grant_id;
  logic              b_err_sticky;

  int         vec_cnt = 0;
  int         err_cnt = 0;
  exp_t       exp_q[$];
  logic [7:0] pmem [NR][32];
  int         phead [NR];
  int         ptail [NR];
  int         m_ptr;
  int         occ;
  int         depth;
  bit         drain_rand;
  bit         force_full;
  bit         force_amst;
  int         cyc = 0;
  int         first_wr;
  int         last_wr;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .write_en(write_en), .wdata(wdata), .full(full),
    .amst_full(amst_full), .error(error), .grant_valid(grant_valid),
    .grant_id(grant_id), .err_sticky(err_sticky)
  );

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(3), .BURST_LEN(BL)) dut3 (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_data(b_req_data),
    .req_ready(b_req_ready), .write_en(b_write_en), .wdata(b_wdata), .full(b_full),
    .amst_full(b_amst_full), .error(b_error), .grant_valid(b_grant_valid),
    .grant_id(b_grant_id), .err_sticky(b_err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign full      = force_full || (occ >= depth);
  assign amst_full = force_amst || (occ >= depth - 1);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input int id, input logic [7:0] d);
    if (phead[id] == ptail[id]) begin
      phead[id] = 0;
      ptail[id] = 0;
    end
    pmem[id][ptail[id]] = d;
    ptail[id]++;
  endtask

  task automatic clear_producers();
    for (int i = 0; i < NR; i++) begin
      phead[i] = 0;
      ptail[i] = 0;
    end
  endtask

  // Reference: each grant goes to the next producer with data after the last
  // granted one and carries min(BURST_LEN, words left) beats.
  task automatic plan();
    int   rem [NR];
    int   pos [NR];
    int   c;
    int   n;
    exp_t e;
    for (int i = 0; i < NR; i++) begin
      rem[i] = ptail[i] - phead[i];
      pos[i] = phead[i];
    end
    c = 0;
    while (c >= 0) begin
      c = -1;
      for (int k = 1; k <= NR; k++) begin
        if (c < 0 && rem[(m_ptr + k) % NR] > 0) c = (m_ptr + k) % NR;
      end
      if (c >= 0) begin
        n = (rem[c] < BL) ? rem[c] : BL;
        for (int b = 0; b < n; b++) begin
          e.id   = 2'(c);
          e.data = pmem[c][pos[c]];
          exp_q.push_back(e);
          pos[c]++;
        end
        rem[c] -= n;
        m_ptr = c;
      end
    end
  endtask

  task automatic wait_done(input string name, input int maxc);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || grant_valid) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_complete"}, (c < maxc), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_producers();
    exp_q.delete();
    m_ptr = NR - 1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Producers and FIFO model: handshakes are sampled mid-low-phase and
  // applied just after the following rising edge.
  initial begin
    logic [NR-1:0] hs;
    logic          wr;
    req_valid = '0;
    req_data  = '0;
    occ       = 0;
    forever begin
      @(negedge clk);
      #2;
      hs = req_valid & req_ready;
      wr = write_en;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (hs[i]) phead[i]++;
      if (rst) begin
        occ = 0;
      end else begin
        occ += int'(wr);
        if (occ > 0 && (!drain_rand || $urandom_range(0, 2) == 0)) occ--;
      end
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = (phead[i] != ptail[i]);
        req_data[i*DW +: DW] = req_valid[i] ? pmem[i][phead[i]] : '0;
      end
    end
  end

  // Monitor: every FIFO write is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (write_en) begin
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL wr_unexpected: got id=%0d data=0x%02h, expected no write", grant_id, wdata);
        end else begin
          e = exp_q.pop_front();
          if (wdata !== e.data || grant_id !== e.id) begin
            err_cnt++;
            $display("FAIL wr_data: got id=%0d data=0x%02h, expected id=%0d data=0x%02h",
                     grant_id, wdata, e.id, e.data);
          end
        end
        vec_cnt++;
        if (occ >= depth) begin
          err_cnt++;
          $display("FAIL overflow: got occupancy %0d at write, expected below %0d", occ, depth);
        end
      end
    end
  end

  initial begin
    #2000000;
    err_cnt++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int   got[$];
    int   exp6 [4];
    logic prev;
    exp_t e;
    rst = 1'b1; error = 1'b0; force_full = 1'b0; force_amst = 1'b0;
    depth = 64; drain_rand = 1'b0; m_ptr = NR - 1; first_wr = -1; last_wr = -1;
    b_rst = 1'b1; b_req_valid = '0; b_req_data = {8'h33, 8'h22, 8'h11};
    b_full = 1'b0; b_amst_full = 1'b0; b_error = 1'b0;
    clear_producers();
    repeat (3) @(negedge clk);
    chk("rst_write_en", write_en, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_err_sticky", err_sticky, 0);
    rst = 1'b0;

    // Single producer 2, three beats, then valid drops.
    load(2, 8'h11); load(2, 8'h22); load(2, 8'h33); plan();
    @(negedge clk); chk("t1_arb_cycle", grant_valid, 0);
    @(negedge clk); chk("t1_grant_valid", grant_valid, 1);
    chk("t1_grant_id", grant_id, 2);
    chk("t1_req_ready", req_ready, 4'b0100);
    wait_done("t1", 50);
    chk("t1_grant_drop", grant_valid, 0);

    // All producers busy: 8 bursts of 4 with one bubble each.
    do_reset();
    first_wr = -1;
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < 8; j++) load(i, 8'(i * 16 + j));
    plan();
    wait_done("t2", 200);
    chk("t2_write_span", last_wr - first_wr, 38);

    // Almost-full with a pending write, then full for five cycles.
    for (int j = 0; j < 4; j++) load(0, 8'(8'hA0 + j));
    plan();
    repeat (3) @(negedge clk);
    chk("t3_first_write", write_en, 1);
    force_amst = 1'b1; #1;
    chk("t3_amst_ready", req_ready[0], 0);
    @(negedge clk);
    chk("t3_amst_no_pending_ready", req_ready[0], 1);
    force_amst = 1'b0; force_full = 1'b1; #1;
    chk("t3_full_ready", req_ready[0], 0);
    repeat (5) begin
      @(negedge clk);
      chk("t3_full_no_write", write_en, 0);
      chk("t3_grant_held", {grant_valid, grant_id}, 3'b100);
    end
    force_full = 1'b0;
    wait_done("t3", 50);

    // Error pulse mid-burst.
    for (int j = 0; j < 6; j++) load(1, 8'(8'hC0 + j));
    plan();
    repeat (4) @(negedge clk);
    chk("t4_err_before", err_sticky, 0);
    error = 1'b1;
    @(negedge clk); error = 1'b0;
    chk("t4_err_set", err_sticky, 1);
    wait_done("t4", 80);
    chk("t4_err_kept", err_sticky, 1);
    do_reset();
    chk("t4_err_cleared", err_sticky, 0);

    // Reset on the second beat of a burst.
    for (int j = 0; j < 4; j++) load(0, 8'(8'h50 + j));
    e.id = 2'd0; e.data = 8'h50; exp_q.push_back(e);
    repeat (3) @(negedge clk);
    chk("t5_first_write", write_en, 1);
    rst = 1'b1; clear_producers(); #1;
    chk("t5_ready_in_rst", req_ready, 0);
    @(negedge clk);
    chk("t5_write_en_after", write_en, 0);
    chk("t5_grant_after", grant_valid, 0);
    chk("t5_ready_after", req_ready, 0);
    rst = 1'b0; m_ptr = NR - 1;
    load(1, 8'h61); load(1, 8'h62); load(3, 8'h63); load(3, 8'h64); plan();
    repeat (2) @(negedge clk);
    chk("t5_regrant_valid", grant_valid, 1);
    chk("t5_regrant_id", grant_id, 1);
    wait_done("t5", 50);

    // Randomized loads with a shallow, randomly drained FIFO.
    depth = 4; drain_rand = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NR; i++) begin
        int n;
        n = $urandom_range(0, 10);
        for (int j = 0; j < n; j++) load(i, 8'($urandom));
      end
      plan();
      wait_done("rand", 2000);
    end
    chk("rand_no_error", err_sticky, 0);

    // Three producers, 0 and 2 requesting: grants must alternate across the wrap.
    @(negedge clk);
    b_rst = 1'b0; b_req_valid = 3'b101;
    prev = 1'b0;
    for (int c = 0; c < 200 && got.size() < 4; c++) begin
      @(negedge clk);
      if (b_grant_valid && !prev) got.push_back(int'(b_grant_id));
      prev = b_grant_valid;
    end
    exp6 = '{0, 2, 0, 2};
    chk("t6_grants_seen", got.size(), 4);
    for (int k = 0; k < got.size() && k < 4; k++)
      chk($sformatf("t6_grant%0d", k), got[k], exp6[k]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
